// File: rtl/riscv_dtcm_if.sv
// LSU data-port bundle between the core (master) and the data TCM (slave).
// Handshake: the master presents a request when rd, any write strobe, flush or
// invalidate is set; the request is taken on a rising edge where the slave
// drives mem_accept_o high. Each taken request gets exactly one response
// (mem_ack_o) on the following cycle, in order, with no response backpressure.
interface riscv_dtcm_if;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_wr_i;
  logic        mem_rd_i;
  logic [3:0]  mem_wr_i;
  logic        mem_cacheable_i;
  logic [10:0] mem_req_tag_i;
  logic        mem_invalidate_i;
  logic        mem_flush_i;
  logic [31:0] mem_data_rd_o;
  logic        mem_accept_o;
  logic        mem_ack_o;
  logic        mem_error_o;
  logic [10:0] mem_resp_tag_o;

  modport master (
    output mem_addr_i, mem_data_wr_i, mem_rd_i, mem_wr_i, mem_cacheable_i,
           mem_req_tag_i, mem_invalidate_i, mem_flush_i,
    input  mem_data_rd_o, mem_accept_o, mem_ack_o, mem_error_o, mem_resp_tag_o
  );

  modport slave (
    input  mem_addr_i, mem_data_wr_i, mem_rd_i, mem_wr_i, mem_cacheable_i,
           mem_req_tag_i, mem_invalidate_i, mem_flush_i,
    output mem_data_rd_o, mem_accept_o, mem_ack_o, mem_error_o, mem_resp_tag_o
  );
endinterface

// File: rtl/riscv_dtcm.sv
// Data-side tightly-coupled memory. Single-port word RAM with byte-lane writes,
// tag echo and an address-range error check. After every reset the RAM is
// zero-cleared by a background sweep (CLEAR) before requests are accepted (RUN).
module riscv_dtcm #(
  parameter int          SIZE_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  riscv_dtcm_if.slave        bus,
  output logic               dbg_state
);
  localparam int AW = $clog2(SIZE_WORDS);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] clr_idx;

  logic [31:0]   ram [SIZE_WORDS];

  logic          req_present;
  logic          req_taken;
  logic          is_write;
  logic          is_read;
  logic          in_range;
  logic [AW-1:0] word_idx;

  logic [3:0]    ram_we;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_wdata;

  // Cacheability and the byte offset carry no meaning for a word TCM.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, bus.mem_cacheable_i, bus.mem_addr_i[1:0]};

  assign dbg_state = state;

  // Request decode; a write strobe takes priority over a read in the same request.
  always_comb begin
    req_present = bus.mem_rd_i | (|bus.mem_wr_i) | bus.mem_flush_i | bus.mem_invalidate_i;
    req_taken   = req_present & bus.mem_accept_o;
    is_write    = |bus.mem_wr_i;
    is_read     = bus.mem_rd_i & ~is_write;
    in_range    = (bus.mem_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
    word_idx    = bus.mem_addr_i[AW+1:2];
  end

  // Single RAM write port: the clear sweep owns it in CLEAR, in-range writes in RUN.
  always_comb begin
    ram_we    = 4'b0000;
    ram_idx   = word_idx;
    ram_wdata = bus.mem_data_wr_i;
    if (state == ST_CLEAR) begin
      ram_we    = 4'b1111;
      ram_idx   = clr_idx;
      ram_wdata = 32'h0;
    end else if (req_taken && is_write && in_range) begin
      ram_we    = bus.mem_wr_i;
    end
  end

  // RAM storage with per-byte write enables; contents are not reset, the sweep clears them.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we[b]) begin
        ram[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  // Clear/run FSM with registered accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= ST_CLEAR;
      clr_idx          <= '0;
      bus.mem_accept_o <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == AW'(SIZE_WORDS - 1)) begin
            state            <= ST_RUN;
            bus.mem_accept_o <= 1'b1;
          end
        end
        default: begin
          state            <= ST_RUN;
          bus.mem_accept_o <= 1'b1;
        end
      endcase
    end
  end

  // Response register: one ack per taken request, one cycle later. Read data is
  // the RAM word before any write that lands on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.mem_ack_o      <= 1'b0;
      bus.mem_error_o    <= 1'b0;
      bus.mem_resp_tag_o <= 11'h0;
      bus.mem_data_rd_o  <= 32'h0;
    end else begin
      bus.mem_ack_o     <= req_taken;
      bus.mem_error_o   <= req_taken & (is_write | bus.mem_rd_i) & ~in_range;
      bus.mem_data_rd_o <= (req_taken && is_read && in_range) ? ram[word_idx] : 32'h0;
      if (req_taken) begin
        bus.mem_resp_tag_o <= bus.mem_req_tag_i;
      end
    end
  end
endmodule
